// File: rtl/mul_seq_unit_if.sv
// Operand/result bundle between the controller/register file and the
// iterative multiplier.
interface mul_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             isSigned;
  logic             longFlag;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] resultLo;
  logic [WIDTH-1:0] resultHi;
  logic [1:0]       mulFlags;

  modport master (
    output start, srcA, srcB, isSigned, longFlag,
    input  busy, done, resultLo, resultHi, mulFlags
  );

  modport slave (
    input  start, srcA, srcB, isSigned, longFlag,
    output busy, done, resultLo, resultHi, mulFlags
  );
endinterface

// File: rtl/mul_seq_unit.sv
// Radix-2 shift-add multiplier for MUL/UMULL/SMULL: WIDTH add iterations on
// operand magnitudes, then a sign-fixup/writeback cycle and a one-cycle done.
module mul_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input logic           clk,
  input logic           reset,
  mul_seq_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               long_q, long_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [1:0]         flags_q, flags_d;
  logic               sgn;
  logic [2*WIDTH-1:0] prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      long_q   <= 1'b0;
      neg_q    <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= 2'b01;
    end else begin
      state_q  <= state_d;
      long_q   <= long_d;
      neg_q    <= neg_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    long_d   = long_q;
    neg_d    = neg_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flags_d  = flags_q;
    sgn      = 1'b0;
    prod     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sgn     = bus.isSigned & bus.longFlag;
          long_d  = bus.longFlag;
          mag_a_d = (sgn && bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
          mag_b_d = (sgn && bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;
          neg_d   = sgn & (bus.srcA[WIDTH-1] ^ bus.srcB[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == CNTW'(WIDTH)) begin
          // Sign fixup on the full 2W product; the short form keeps only the low word.
          prod     = neg_q ? -acc_q : acc_q;
          res_lo_d = prod[WIDTH-1:0];
          res_hi_d = long_q ? prod[2*WIDTH-1:WIDTH] : '0;
          flags_d  = {(long_q ? prod[2*WIDTH-1] : prod[WIDTH-1]),
                      ~|{res_hi_d, res_lo_d}};
          state_d  = S_DONE;
        end else begin
          if (mag_b_q[0]) begin
            acc_d = acc_q + ({{WIDTH{1'b0}}, mag_a_q} << cnt_q);
          end
          mag_b_d = mag_b_q >> 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.resultLo = res_lo_q;
  assign bus.resultHi = res_hi_q;
  assign bus.mulFlags = flags_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Randomized and directed bench for mul_seq_unit against a transaction-level
// product model with a cycle-by-cycle output compare.
module tb_mul_seq_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_seq_unit_if #(.WIDTH(W)) bus ();

  mul_seq_unit #(.WIDTH(W), .CNTW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: product computed with plain wide arithmetic; cycles remaining
  // until idle tracked as a single countdown.
  int          rem;
  logic [31:0] m_lo, m_hi, p_lo, p_hi;
  logic [1:0]  m_fl, p_fl;

  task automatic model_prod(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input logic l, output logic [31:0] lo, output logic [31:0] hi,
                            output logic [1:0] fl);
    logic [63:0] p;
    if (l && s) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    else        p = {32'b0, a} * {32'b0, b};
    lo = p[31:0];
    hi = l ? p[63:32] : 32'h0;
    fl = {(l ? hi[31] : lo[31]), ({hi, lo} == 64'h0)};
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rem  = 0;
      m_lo = '0;
      m_hi = '0;
      m_fl = 2'b01;
    end else if (rem == 0) begin
      if (bus.start) begin
        model_prod(bus.srcA, bus.srcB, bus.isSigned, bus.longFlag, p_lo, p_hi, p_fl);
        rem = W + 2;
      end
    end else begin
      rem = rem - 1;
      if (rem == 1) begin
        m_lo = p_lo;
        m_hi = p_hi;
        m_fl = p_fl;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",     {63'b0, bus.busy}, {63'b0, (rem > 0)});
    chk("done",     {63'b0, bus.done}, {63'b0, (rem == 1)});
    chk("resultLo", {32'b0, bus.resultLo}, {32'b0, m_lo});
    chk("resultHi", {32'b0, bus.resultHi}, {32'b0, m_hi});
    chk("mulFlags", {62'b0, bus.mulFlags}, {62'b0, m_fl});
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic l, input logic [31:0] elo,
                        input logic [31:0] ehi, input logic [1:0] ef);
    int cyc = 0;
    wait_idle();
    bus.srcA = a; bus.srcB = b; bus.isSigned = s; bus.longFlag = l; bus.start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.srcA = $urandom; bus.srcB = $urandom;
    bus.isSigned = ~s; bus.longFlag = ~l;
    while (!bus.done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'(W + 1));
    chk({nm, "_lo"}, {32'b0, bus.resultLo}, {32'b0, elo});
    chk({nm, "_hi"}, {32'b0, bus.resultHi}, {32'b0, ehi});
    chk({nm, "_flags"}, {62'b0, bus.mulFlags}, {62'b0, ef});
    @(posedge clk); #1;
    chk({nm, "_busy_fall"}, {63'b0, bus.busy}, 64'h0);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses;
    reset = 1'b1;
    bus.start = 1'b0; bus.srcA = '0; bus.srcB = '0;
    bus.isSigned = 1'b0; bus.longFlag = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {62'b0, bus.mulFlags}, 64'h1);
    reset = 1'b0;

    run_op("mul7x6",  32'd7,        32'd6,        1'b0, 1'b0, 32'h2A,       32'h0,        2'b00);
    run_op("umull_ff",32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h1,        32'hFFFFFFFE, 2'b10);
    run_op("smull_m2",32'hFFFFFFFE, 32'd3,        1'b1, 1'b1, 32'hFFFFFFFA, 32'hFFFFFFFF, 2'b10);
    run_op("smull_min",32'h80000000,32'h80000000, 1'b1, 1'b1, 32'h0,        32'h40000000, 2'b00);
    run_op("mul_zero",32'h0,        32'h1234,     1'b0, 1'b0, 32'h0,        32'h0,        2'b01);
    run_op("mul_sgnig",32'hFFFFFFFF,32'd2,        1'b1, 1'b0, 32'hFFFFFFFE, 32'h0,        2'b10);

    // start re-pulsed mid-run must not spawn a second operation
    wait_idle();
    bus.srcA = 32'd100; bus.srcB = 32'd9; bus.isSigned = 1'b0; bus.longFlag = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.srcA = 32'd3; bus.srcB = 32'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 2 * W + 10; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        pulses++;
        chk("ign_lo", {32'b0, bus.resultLo}, 64'd900);
      end
    end
    chk("ign_pulses", 64'(pulses), 64'd1);

    // asynchronous reset in the middle of a UMULL
    wait_idle();
    bus.srcA = 32'hDEADBEEF; bus.srcB = 32'h12345678; bus.isSigned = 1'b0; bus.longFlag = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy",  {63'b0, bus.busy}, 64'h0);
    chk("arst_done",  {63'b0, bus.done}, 64'h0);
    chk("arst_lo",    {32'b0, bus.resultLo}, 64'h0);
    chk("arst_hi",    {32'b0, bus.resultHi}, 64'h0);
    chk("arst_flags", {62'b0, bus.mulFlags}, 64'h1);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    chk("arst_nodone", 64'(pulses), 64'd0);
    run_op("post_rst", 32'd7, 32'd6, 1'b0, 1'b0, 32'h2A, 32'h0, 2'b00);

    // random traffic, including starts held or pulsed while busy
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.srcA     = rnd_op();
      bus.srcB     = rnd_op();
      bus.isSigned = $urandom_range(0, 1);
      bus.longFlag = $urandom_range(0, 1);
    end
    bus.start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
